trap_ctrl: RTL and testbench



---
 rtl/trap_ctrl_pkg.sv | 36 +++
 rtl/trap_oldest_sel.sv | 26 ++
 rtl/trap_ctrl.sv | 137 +++++++++++++
 tb/tb_trap_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared core types for the trap controller: ROB index, trap payload, FSM states
// and the wrap-aware ROB age comparison.
package trap_ctrl_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_IDX_W = 6;

    typedef struct packed {
        logic                 flipped;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef struct packed {
        robIdx_t         rob_idx;
        logic [15:0]     cause;
        logic [XLEN-1:0] epc;
        logic [XLEN-1:0] tval;
    } trapInfo_t;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FLUSH,
        DELIVER
    } trap_state_e;

    localparam logic [15:0] CAUSE_IRQ_BIT  = 16'h8000;
    localparam logic [15:0] CAUSE_EXC_MASK = 16'h7fff;

    // The flipped bit marks which lap of the circular ROB an index belongs to.
    function automatic logic is_older(input robIdx_t a, input robIdx_t b);
        return ((a.flipped == b.flipped) && (a.idx < b.idx)) ||
               ((a.flipped != b.flipped) && (a.idx > b.idx));
    endfunction

endpackage

// File: rtl/trap_oldest_sel.sv
// Combinational oldest-of-N picker over trap candidates; on equal age the
// lowest candidate slot wins.
module trap_oldest_sel
    import trap_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] vld,
    input  trapInfo_t    cand [N],
    output logic         sel_vld,
    output trapInfo_t    sel
);

    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path can infer a latch.
        sel_vld = 1'b0;
        sel     = '0;
        for (int i = 0; i < N; i++) begin
            if (vld[i] && (!sel_vld || is_older(cand[i].rob_idx, sel.rob_idx))) begin
                sel_vld = 1'b1;
                sel     = cand[i];
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: keeps the oldest outstanding exception, blocks the ROB head
// when it is reached, flushes the pipeline and hands the trap to the CSR unit.
// Optional interrupt injection at the ROB head is enabled by TRAP_CTRL_IRQ_EN.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  i_exc_vld,
    input  robIdx_t             i_exc_robIdx [NUM_SRC],
    input  logic [15:0]         i_exc_cause  [NUM_SRC],
    input  logic [XLEN-1:0]     i_exc_epc    [NUM_SRC],
    input  logic [XLEN-1:0]     i_exc_tval   [NUM_SRC],
    input  logic                i_squash_vld,
    input  robIdx_t             i_squash_robIdx,
    input  logic                i_commit_vld,
    input  robIdx_t             i_commit_robIdx,
    input  logic                i_irq_vld,
    input  logic [15:0]         i_irq_cause,
    output logic                o_commit_block,
    output logic                o_flush,
    output logic                o_trap_vld,
    output trapInfo_t           o_trap_info,
    input  logic                i_trap_rdy
);

    localparam int N_CAND = NUM_SRC + 1;

    trap_state_e         state_q;
    trapInfo_t           pend_q;
    logic                pend_kill;
    logic                accepting;
    logic                commit_match;
    logic                irq_take;
    logic [N_CAND-1:0]   cand_vld;
    trapInfo_t           cand [N_CAND];
    logic                sel_vld;
    trapInfo_t           sel;

    assign accepting = (state_q == IDLE) || (state_q == PEND);
    assign pend_kill = i_squash_vld && is_older(i_squash_robIdx, pend_q.rob_idx);

    // Slot 0 is the held entry so it keeps priority over an equally old report.
    always_comb begin
        cand_vld    = '0;
        cand[0]     = pend_q;
        cand_vld[0] = (state_q == PEND) && !pend_kill;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand[i+1].rob_idx = i_exc_robIdx[i];
            cand[i+1].cause   = i_exc_cause[i] & CAUSE_EXC_MASK;
            cand[i+1].epc     = i_exc_epc[i];
            cand[i+1].tval    = i_exc_tval[i];
            cand_vld[i+1]     = accepting && i_exc_vld[i] &&
                                !(i_squash_vld && is_older(i_squash_robIdx, i_exc_robIdx[i]));
        end
    end

    trap_oldest_sel #(.N(N_CAND)) u_oldest_sel (
        .vld     (cand_vld),
        .cand    (cand),
        .sel_vld (sel_vld),
        .sel     (sel)
    );

    assign commit_match = (state_q == PEND) && !pend_kill && i_commit_vld &&
                          (i_commit_robIdx == pend_q.rob_idx);

`ifdef TRAP_CTRL_IRQ_EN
    trapInfo_t irq_info;
    logic      irq_unused;

    assign irq_take   = (state_q == IDLE) && i_irq_vld && i_commit_vld;
    assign irq_unused = i_irq_cause[15];

    // epc stays zero here; the CSR unit fills it from the head pc.
    always_comb begin
        irq_info         = '0;
        irq_info.rob_idx = i_commit_robIdx;
        irq_info.cause   = CAUSE_IRQ_BIT | (i_irq_cause & CAUSE_EXC_MASK);
    end
`else
    logic irq_unused;

    assign irq_take   = 1'b0;
    assign irq_unused = ^{i_irq_vld, i_irq_cause};
`endif

    // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef TRAP_CTRL_IRQ_EN
                    if (irq_take) begin
                        pend_q  <= irq_info;
                        state_q <= FLUSH;
                    end else
`endif
                    if (sel_vld) begin
                        pend_q  <= sel;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (commit_match) begin
                        state_q <= FLUSH;
                    end else if (sel_vld) begin
                        pend_q  <= sel;
                    end else begin
                        pend_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                FLUSH: state_q <= DELIVER;
                DELIVER: begin
                    if (i_trap_rdy) begin
                        pend_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_flush        = (state_q == FLUSH);
    assign o_trap_vld     = (state_q == DELIVER);
    assign o_trap_info    = pend_q;
    assign o_commit_block = commit_match || irq_take ||
                            (state_q == FLUSH) || (state_q == DELIVER);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl: selection, wrap-around age,
// squash, flush/deliver timing, backpressure, reset and optional interrupts.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int NUM_SRC = 3;

    logic               clk;
    logic               rst;
    logic [NUM_SRC-1:0] exc_vld;
    robIdx_t            exc_rob   [NUM_SRC];
    logic [15:0]        exc_cause [NUM_SRC];
    logic [XLEN-1:0]    exc_epc   [NUM_SRC];
    logic [XLEN-1:0]    exc_tval  [NUM_SRC];
    logic               squash_vld;
    robIdx_t            squash_rob;
    logic               commit_vld;
    robIdx_t            commit_rob;
    logic               irq_vld;
    logic [15:0]        irq_cause;
    logic               commit_block;
    logic               flush;
    logic               trap_vld;
    trapInfo_t          trap_info;
    logic               trap_rdy;

    int checks = 0;
    int errors = 0;

    trap_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_exc_vld       (exc_vld),
        .i_exc_robIdx    (exc_rob),
        .i_exc_cause     (exc_cause),
        .i_exc_epc       (exc_epc),
        .i_exc_tval      (exc_tval),
        .i_squash_vld    (squash_vld),
        .i_squash_robIdx (squash_rob),
        .i_commit_vld    (commit_vld),
        .i_commit_robIdx (commit_rob),
        .i_irq_vld       (irq_vld),
        .i_irq_cause     (irq_cause),
        .o_commit_block  (commit_block),
        .o_flush         (flush),
        .o_trap_vld      (trap_vld),
        .o_trap_info     (trap_info),
        .i_trap_rdy      (trap_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic robIdx_t mk(input logic fl, input int idx);
        robIdx_t r;
        r.flipped = fl;
        r.idx     = idx[ROB_IDX_W-1:0];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        exc_vld    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            exc_rob[i]   = '0;
            exc_cause[i] = '0;
            exc_epc[i]   = '0;
            exc_tval[i]  = '0;
        end
        squash_vld = 1'b0;
        squash_rob = '0;
        commit_vld = 1'b0;
        commit_rob = '0;
        irq_vld    = 1'b0;
        irq_cause  = '0;
        trap_rdy   = 1'b0;
    endtask

    task automatic set_exc(input int src, input logic fl, input int idx, input logic [15:0] cause,
                           input logic [XLEN-1:0] epc, input logic [XLEN-1:0] tval);
        exc_vld[src]   = 1'b1;
        exc_rob[src]   = mk(fl, idx);
        exc_cause[src] = cause;
        exc_epc[src]   = epc;
        exc_tval[src]  = tval;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_state", dut.state_q, IDLE);
        check("rst_flush", flush, 0);
        check("rst_trap_vld", trap_vld, 0);
        check("rst_block", commit_block, 0);
        check("rst_info", |trap_info, 0);
        rst = 1'b0;
        tick();

        // Oldest of two sources wins regardless of source number.
        set_exc(2, 1'b0, 10, 16'd5, 32'h0000_2000, 32'h0);
        set_exc(0, 1'b0, 12, 16'd2, 32'h0000_3000, 32'h0);
        tick();
        clear_inputs();
        check("sel_state", dut.state_q, PEND);
        check("sel_rob", trap_info.rob_idx, 7'h0a);
        check("sel_cause", trap_info.cause, 16'd5);
        check("sel_no_flush", flush, 0);

        // Equal-age reports resolve to the lower source.
        set_exc(0, 1'b0, 8, 16'd3, 32'h0000_0100, 32'h0000_00ab);
        set_exc(1, 1'b0, 8, 16'd4, 32'h0000_0200, 32'h0000_00cd);
        tick();
        clear_inputs();
        check("tie_rob", trap_info.rob_idx, 7'h08);
        check("tie_cause", trap_info.cause, 16'd3);
        check("tie_tval", trap_info.tval, 32'h0000_00ab);

        commit_vld = 1'b1;
        commit_rob = mk(1'b0, 5);
        #1;
        check("nomatch_block", commit_block, 0);
        tick();
        clear_inputs();
        check("nomatch_state", dut.state_q, PEND);

        commit_vld = 1'b1;
        commit_rob = mk(1'b0, 8);
        #1;
        check("match_block", commit_block, 1);
        tick();
        clear_inputs();
        check("n1_flush", flush, 1);
        check("n1_trap_vld", trap_vld, 0);
        check("n1_block", commit_block, 1);
        // Traffic during FLUSH must not disturb the trap.
        set_exc(0, 1'b0, 1, 16'd11, 32'h0, 32'h0);
        squash_vld = 1'b1;
        squash_rob = mk(1'b0, 0);
        tick();
        clear_inputs();
        check("n2_flush", flush, 0);
        check("n2_trap_vld", trap_vld, 1);
        check("n2_rob", trap_info.rob_idx, 7'h08);
        check("n2_cause", trap_info.cause, 16'd3);
        check("n2_epc", trap_info.epc, 32'h0000_0100);
        trap_rdy = 1'b1;
        tick();
        clear_inputs();
        check("hs_state", dut.state_q, IDLE);
        check("hs_trap_vld", trap_vld, 0);
        check("hs_info", |trap_info, 0);

        // Wrapped report {1,1} is younger than pending {0,62}.
        set_exc(1, 1'b0, 62, 16'd5, 32'h8000_0100, 32'h0);
        tick();
        clear_inputs();
        set_exc(0, 1'b1, 1, 16'd2, 32'h8000_0200, 32'h0);
        tick();
        clear_inputs();
        check("wrap_rob", trap_info.rob_idx, 7'h3e);
        check("wrap_cause", trap_info.cause, 16'd5);
        commit_vld = 1'b1;
        commit_rob = mk(1'b0, 62);
        tick();
        clear_inputs();
        check("wrap_flush", flush, 1);
        tick();
        check("wrap_trap_vld", trap_vld, 1);
        check("wrap_trap_cause", trap_info.cause, 16'd5);
        check("wrap_epc", trap_info.epc, 32'h8000_0100);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("bp_trap_vld", trap_vld, 1);
            check("bp_rob", trap_info.rob_idx, 7'h3e);
            check("bp_cause", trap_info.cause, 16'd5);
            check("bp_block", commit_block, 1);
        end
        trap_rdy = 1'b1;
        tick();
        clear_inputs();
        check("bp_done_state", dut.state_q, IDLE);
        check("bp_done_block", commit_block, 0);

        // Squash of the pending entry returns to IDLE; its later commit is harmless.
        set_exc(0, 1'b0, 20, 16'd4, 32'h0, 32'h0);
        tick();
        clear_inputs();
        squash_vld = 1'b1;
        squash_rob = mk(1'b0, 15);
        tick();
        clear_inputs();
        check("sq_state", dut.state_q, IDLE);
        commit_vld = 1'b1;
        commit_rob = mk(1'b0, 20);
        #1;
        check("sq_block", commit_block, 0);
        tick();
        clear_inputs();
        check("sq_no_flush", flush, 0);
        check("sq_state_after", dut.state_q, IDLE);

        // Same-cycle squash filters younger reports, keeps older ones.
        squash_vld = 1'b1;
        squash_rob = mk(1'b0, 15);
        set_exc(0, 1'b0, 16, 16'd1, 32'h0, 32'h0);
        set_exc(1, 1'b0, 14, 16'd6, 32'h0, 32'h0);
        tick();
        clear_inputs();
        check("sqf_rob", trap_info.rob_idx, 7'h0e);
        check("sqf_cause", trap_info.cause, 16'd6);
        squash_vld = 1'b1;
        squash_rob = mk(1'b0, 13);
        tick();
        clear_inputs();
        check("sqf_kill_state", dut.state_q, IDLE);

        // Reset in DELIVER drops the trap.
        set_exc(0, 1'b0, 3, 16'd7, 32'h0, 32'h0);
        tick();
        clear_inputs();
        commit_vld = 1'b1;
        commit_rob = mk(1'b0, 3);
        tick();
        clear_inputs();
        tick();
        check("rd_trap_vld", trap_vld, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rd_state", dut.state_q, IDLE);
        check("rd_trap_vld0", trap_vld, 0);
        check("rd_flush", flush, 0);
        check("rd_block", commit_block, 0);
        check("rd_info", |trap_info, 0);
        tick();

`ifdef TRAP_CTRL_IRQ_EN
        irq_vld    = 1'b1;
        irq_cause  = 16'd7;
        commit_vld = 1'b1;
        commit_rob = mk(1'b0, 30);
        #1;
        check("irq_block", commit_block, 1);
        tick();
        clear_inputs();
        check("irq_flush", flush, 1);
        tick();
        check("irq_trap_vld", trap_vld, 1);
        check("irq_cause", trap_info.cause, 16'h8007);
        check("irq_epc", trap_info.epc, 0);
        check("irq_rob", trap_info.rob_idx, 7'h1e);
        trap_rdy = 1'b1;
        tick();
        clear_inputs();
        set_exc(0, 1'b0, 31, 16'd2, 32'h0, 32'h0);
        tick();
        clear_inputs();
        irq_vld    = 1'b1;
        irq_cause  = 16'd7;
        commit_vld = 1'b1;
        commit_rob = mk(1'b0, 31);
        tick();
        clear_inputs();
        tick();
        check("irqx_trap_vld", trap_vld, 1);
        check("irqx_cause", trap_info.cause, 16'd2);
        trap_rdy = 1'b1;
        tick();
        clear_inputs();
`else
        irq_vld    = 1'b1;
        irq_cause  = 16'd7;
        commit_vld = 1'b1;
        commit_rob = mk(1'b0, 30);
        #1;
        check("noirq_block", commit_block, 0);
        tick();
        clear_inputs();
        check("noirq_flush", flush, 0);
        check("noirq_state", dut.state_q, IDLE);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
